imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Controller that owns the single port of the 16x12 instruction memory and shares it between a program loader and the CPU fetch path. It runs in two phases. In the load phase it accepts a valid/ready write stream into sequential addresses. In the run phase it sequences reads from a program counter, applies branches, and presents one instruction at a time to the CPU.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 12, instruction width
DEPTH, 16, memory words (must equal 2**ADDR_W)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
load_valid  in  1  loader beat valid
load_data  in  DATA_W  loader instruction word
load_last  in  1  marks final beat of program
load_ready  out  1  controller accepts beat
start  in  1  begin/restart execution from address 0
fetch_req  in  1  CPU consumes current instruction, requests next
branch_valid  in  1  with fetch_req: next PC is branch_addr
branch_addr  in  ADDR_W  branch target
instr_valid  out  1  instr_out/pc_out valid
instr_out  out  DATA_W  current instruction
pc_out  out  ADDR_W  address of instr_out
prog_len  out  ADDR_W+1  number of words loaded (0..16)
done  out  1  program finished (sticky)
mem_wr_en  out  1  to memory write enable
mem_addr  out  ADDR_W  to memory address
mem_write_data  out  DATA_W  to memory write data
mem_instruction  in  DATA_W  memory registered read data (1-cycle latency)

Behaviour:
- States: S_LOAD (reset state), S_LOADED, S_ISSUE, S_WAIT, S_VALID, S_DONE.
- Reset (reset==0 at an edge):
  - state=S_LOAD; wr_ptr=0; pc=0; prog_len=0; instr_out=0; pc_out=0; instr_valid=0; done=0.
  - Memory contents are not touched by this block.
  - Reset in any state, including mid-load or mid-fetch, aborts immediately.
- Combinational outputs:
  - load_ready = (state==S_LOAD).
  - mem_wr_en = load_valid & load_ready.
  - mem_write_data = load_data.
  - mem_addr = wr_ptr in S_LOAD, else pc.
- S_LOAD:
  - Each accepted beat writes mem[wr_ptr], wr_ptr++, prog_len++.
  - Goes to S_LOADED after an accepted beat with load_last=1, or after the 16th accepted beat regardless of load_last (full). No further beats are accepted.
  - start with no accepted beat in the same cycle goes to S_LOADED; this allows an empty or partial program.
  - start in the same cycle as an accepted beat: beat is written, start is ignored.
- S_LOADED: start -> pc=0, go to S_DONE if prog_len==0, else S_ISSUE. Other inputs ignored.
- S_ISSUE: read addressed at pc. Go to S_WAIT.
- S_WAIT: instr_out<=mem_instruction, pc_out<=pc, instr_valid<=1. Go to S_VALID.
- S_VALID:
  - instr_valid=1; instr_out/pc_out held stable until fetch_req.
  - fetch_req & branch_valid: pc<=branch_addr, instr_valid<=0, go to S_ISSUE.
  - fetch_req & !branch_valid & pc==prog_len-1: instr_valid<=0, done<=1, go to S_DONE.
  - fetch_req & !branch_valid otherwise: pc<=pc+1 (wraps 15->0), instr_valid<=0, go to S_ISSUE.
  - branch_valid without fetch_req is ignored.
  - Branch targets >= prog_len are fetched as-is. Termination is checked only on a sequential advance.
- S_DONE: done=1, instr_valid=0. start -> done<=0, pc=0, go to S_ISSUE (re-run; memory keeps the program). Reload is only possible via reset.
- Latency:
  - start sampled at edge T -> instr_valid high from T+3.
  - fetch_req sampled at edge t -> next instr_valid at t+3.
  - instr_valid drops for 2 cycles between instructions.
- start is ignored in S_ISSUE, S_WAIT and S_VALID.

Decomposition:
- Package imem_ctrl_pkg: state enum (state_t), ADDR_W/DATA_W/DEPTH defaults, PROG_LEN_W=ADDR_W+1.
- Single module, no sub-module.
- The memory is instantiated beside this block by the parent, not inside it.

Test Plan:
- Load 12'hA01, 12'hB02, 12'hC03 (last on 3rd), then start -> prog_len=3 and load_ready=0. instr_valid at start+3 with instr_out=12'hA01, pc_out=0. Three fetch_req pulses step through pc 1,2, then done=1.
- Stream 17 beats with load_last=0 -> first 16 written (prog_len=16), load_ready low from the 17th cycle, 17th beat not accepted. Run wraps to done after pc=15.
- start with no load beats -> prog_len=0; next start -> done=1 with instr_valid never asserted.
- In S_VALID at pc=1, fetch_req with branch_valid and branch_addr=0 -> next instr_valid shows pc_out=0 with word0. Repeat without branch -> pc_out=1.
- start and accepted beat in same cycle -> beat written, state stays S_LOAD, prog_len increments.
- reset=0 while in S_WAIT -> next cycle instr_valid=0, done=0, load_ready=1, prog_len=0. Reload of 1 word and run returns that word.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared types and default sizes for the instruction-memory fetch controller.
package imem_ctrl_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 12;
    localparam int DEPTH      = 16;
    localparam int PROG_LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_LOADED,
        S_ISSUE,
        S_WAIT,
        S_VALID,
        S_DONE
    } state_t;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Owns the single instruction-memory port: sequential program load first,
// then PC-driven fetch with branches, presenting one instruction at a time.
module imem_fetch_ctrl #(
    parameter int ADDR_W = imem_ctrl_pkg::ADDR_W,
    parameter int DATA_W = imem_ctrl_pkg::DATA_W,
    parameter int DEPTH  = imem_ctrl_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              fetch_req,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_instruction
);

    import imem_ctrl_pkg::*;

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] LAST_SLOT = LEN_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [LEN_W-1:0]  prog_len_n;
    logic [DATA_W-1:0] instr_out_n;
    logic [ADDR_W-1:0] pc_out_n;
    logic              instr_valid_n;
    logic              done_n;
    logic              beat;

    assign load_ready     = (state == S_LOAD);
    assign beat           = load_valid & load_ready;
    assign mem_wr_en      = beat;
    assign mem_write_data = load_data;
    assign mem_addr       = (state == S_LOAD) ? wr_ptr : pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_LOAD;
            wr_ptr      <= '0;
            pc          <= '0;
            prog_len    <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            pc          <= pc_n;
            prog_len    <= prog_len_n;
            instr_out   <= instr_out_n;
            pc_out      <= pc_out_n;
            instr_valid <= instr_valid_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        wr_ptr_n      = wr_ptr;
        pc_n          = pc;
        prog_len_n    = prog_len;
        instr_out_n   = instr_out;
        pc_out_n      = pc_out;
        instr_valid_n = instr_valid;
        done_n        = done;

        case (state)
            S_LOAD: begin
                // An accepted beat always wins over start in the same cycle.
                if (beat) begin
                    wr_ptr_n   = wr_ptr + 1'b1;
                    prog_len_n = prog_len + 1'b1;
                    if (load_last || prog_len == LAST_SLOT) begin
                        state_n = S_LOADED;
                    end
                end else if (start) begin
                    state_n = S_LOADED;
                end
            end
            S_LOADED: begin
                if (start) begin
                    pc_n = '0;
                    if (prog_len == '0) begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                instr_out_n   = mem_instruction;
                pc_out_n      = pc;
                instr_valid_n = 1'b1;
                state_n       = S_VALID;
            end
            S_VALID: begin
                // Termination is only checked on a sequential advance, so a
                // branch target beyond the program is still fetched.
                if (fetch_req) begin
                    instr_valid_n = 1'b0;
                    if (branch_valid) begin
                        pc_n    = branch_addr;
                        state_n = S_ISSUE;
                    end else if ({1'b0, pc} == prog_len - LEN_W'(1)) begin
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else begin
                        pc_n    = pc + 1'b1;
                        state_n = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    done_n  = 1'b0;
                    pc_n    = '0;
                    state_n = S_ISSUE;
                end
            end
            default: begin
                state_n = S_LOAD;
            end
        endcase
    end

endmodule
